// File: rtl/bank_req_scheduler_pkg.sv
// Purpose : shared sizing defaults and FSM state type for the bank request scheduler.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package bank_req_scheduler_pkg;

  // Default build: P lanes -> 2P requests and 2P banks per batch.
  localparam int DEF_P     = 2;
  // Bits per bank/request index, clog2(2P).
  localparam int DEF_MAP   = 2;
  // Width of the saturating conflict-beat counter.
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/bank_req_scheduler_bank_pick.sv
// Purpose : per-bank picker; finds the lowest-index pending request mapped to this bank.
// Latency : purely combinational.
// Backpr. : none; the caller decides when the pick is consumed.
//
// Ports:
//   bi_i      packed bank index per request, request j at [j*MAP +: MAP]
//   pending_i requests of the current batch not yet issued
//   bank_id_i bank this picker serves
//   hit_o     some pending request targets this bank
//   idx_o     index of the picked request (0 when no hit)
module bank_req_scheduler_bank_pick
  import bank_req_scheduler_pkg::*;
#(
  parameter int NREQ = 2 * DEF_P,
  parameter int MAP  = DEF_MAP
) (
  input  logic [NREQ*MAP-1:0] bi_i,
  input  logic [NREQ-1:0]     pending_i,
  input  logic [MAP-1:0]      bank_id_i,
  output logic                hit_o,
  output logic [MAP-1:0]      idx_o
);

  // Scan from the top down so the last match written is the lowest index.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (pending_i[j] && (bi_i[j*MAP +: MAP] == bank_id_i)) begin
        hit_o = 1'b1;
        idx_o = MAP'(j);
      end
    end
  end

endmodule

// File: rtl/bank_req_scheduler.sv
// Purpose : issues one batch of 2P bank-indexed requests onto 2P banks, one beat per conflict level.
// Latency : first beat one cycle after accept; conflict-free batches stream at one batch per cycle.
// Backpr. : out_ready_i low holds every output and the pending mask; in_ready_o only rises on the final beat.
//
// Ports:
//   clk_i, rst_n_i    clock, async active-low reset
//   in_valid_i/in_ready_o, bi_bus_i      batch input handshake, bank index per request
//   flush_i           drop the pending batch and go idle (beats the accept and the beat)
//   out_valid_o/out_ready_i               beat handshake
//   sel_bi_bus_o      per bank: request index granted this beat (0 if none)
//   bank_en_o         per bank: granted this beat
//   req_grant_o       per request: issued this beat
//   last_o            final beat of the batch
//   busy_o            batch in flight
//   conflict_cnt_o    saturating total of beats beyond the first in each batch
module bank_req_scheduler
  import bank_req_scheduler_pkg::*;
#(
  parameter int P     = DEF_P,
  parameter int MAP   = DEF_MAP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*P*MAP-1:0]   bi_bus_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*P*MAP-1:0]   sel_bi_bus_o,
  output logic [2*P-1:0]       bank_en_o,
  output logic [2*P-1:0]       req_grant_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     conflict_cnt_o
);

  localparam int NREQ = 2 * P;

  state_e                state_q, state_d;
  logic [NREQ*MAP-1:0]   bi_q, bi_d;
  logic [NREQ-1:0]       pending_q, pending_d;
  // Beats already completed in the current batch (0..2P-1 before the last one).
  logic [MAP:0]          beat_q, beat_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NREQ-1:0]       hit;
  logic [NREQ*MAP-1:0]   idx;
  logic [NREQ-1:0]       grant;
  logic                  issue;
  logic                  last_raw;
  logic                  beat_done;
  logic                  accept;
  logic [CNT_W:0]        cnt_sum;

  for (genvar b = 0; b < NREQ; b++) begin : g_bank
    bank_req_scheduler_bank_pick #(
      .NREQ (NREQ),
      .MAP  (MAP)
    ) u_pick (
      .bi_i      (bi_q),
      .pending_i (pending_q),
      .bank_id_i (MAP'(b)),
      .hit_o     (hit[b]),
      .idx_o     (idx[b*MAP +: MAP])
    );
  end

  // Each bank picks a distinct request, so the grants never collide.
  always_comb begin
    grant = '0;
    for (int b = 0; b < NREQ; b++) begin
      if (hit[b]) begin
        grant[idx[b*MAP +: MAP]] = 1'b1;
      end
    end
  end

  assign issue     = (state_q == ISSUE);
  assign last_raw  = ((pending_q & ~grant) == '0);
  assign beat_done = issue & out_ready_i;

  // in_ready_o is the only output with an input-dependent path (out_ready_i, flush_i);
  // all beat outputs decode from registers alone.
  assign in_ready_o = ~flush_i & (~issue | (last_raw & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;

  assign out_valid_o    = issue;
  assign busy_o         = issue;
  assign last_o         = issue & last_raw;
  assign bank_en_o      = issue ? hit   : '0;
  assign req_grant_o    = issue ? grant : '0;
  assign sel_bi_bus_o   = issue ? idx   : '0;
  assign conflict_cnt_o = cnt_q;

  // beat_q at the final beat equals beats-1, i.e. the extra beats of this batch.
  assign cnt_sum = {1'b0, cnt_q} + {{(CNT_W - MAP){1'b0}}, beat_q};

  always_comb begin
    state_d   = state_q;
    bi_d      = bi_q;
    pending_d = pending_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      state_d   = IDLE;
      pending_d = '0;
      beat_d    = '0;
    end else begin
      if (beat_done) begin
        pending_d = pending_q & ~grant;
        if (last_raw) begin
          cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + 1'b1;
        end
      end
      // Accept only happens from IDLE or on a completing last beat, so it
      // cleanly overrides the beat update above (zero-bubble chaining).
      if (accept) begin
        bi_d      = bi_bus_i;
        pending_d = '1;
        state_d   = ISSUE;
        beat_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      bi_q      <= '0;
      pending_q <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bi_q      <= bi_d;
      pending_q <= pending_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bank_req_scheduler.sv
// Purpose : self-checking bench for bank_req_scheduler (P=2, MAP=2).
// Latency : n/a.
// Backpr. : drives random out_ready stalls.
module tb_bank_req_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  bi_bus_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  sel_bi_bus_o;
  logic [3:0]  bank_en_o;
  logic [3:0]  req_grant_o;
  logic        last_o;
  logic        busy_o;
  logic [15:0] conflict_cnt_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt;

  always #5 clk_i = ~clk_i;

  bank_req_scheduler #(.P(2), .MAP(2), .CNT_W(16)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .bi_bus_i       (bi_bus_i),
    .flush_i        (flush_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .sel_bi_bus_o   (sel_bi_bus_o),
    .bank_en_o      (bank_en_o),
    .req_grant_o    (req_grant_o),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] en;
    logic [7:0] sel;
    logic [3:0] gnt;
  } beat_t;

  // Beat k gives each bank the k-th request (ascending index) that maps to it.
  function automatic beat_t model_beat(input logic [7:0] bi, input int k);
    beat_t r;
    int    seen;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      seen = 0;
      for (int j = 0; j < 4; j++) begin
        if (int'(bi[j*2 +: 2]) == b) begin
          if (seen == k) begin
            r.en[b]         = 1'b1;
            r.sel[b*2 +: 2] = 2'(j);
            r.gnt[j]        = 1'b1;
          end
          seen++;
        end
      end
    end
    return r;
  endfunction

  // Beats per batch = largest number of requests sharing one bank.
  function automatic int model_nbeats(input logic [7:0] bi);
    int cnt [4];
    int mx;
    for (int b = 0; b < 4; b++) cnt[b] = 0;
    for (int j = 0; j < 4; j++) cnt[int'(bi[j*2 +: 2])]++;
    mx = 0;
    for (int b = 0; b < 4; b++) if (cnt[b] > mx) mx = cnt[b];
    return mx;
  endfunction

  typedef struct {
    logic [7:0] bi;
    logic [3:0] en;
    logic [7:0] sel;
    logic [3:0] gnt;
    int         nb;
  } vec_t;

  typedef struct {
    beat_t b;
    int    extra;
  } exp_t;

  initial begin
    vec_t       tbl [5];
    exp_t       expq [$];
    logic [7:0] b2b [4];
    beat_t      bt;
    exp_t       e;
    int         nb;
    int         n;
    logic       done;
    logic       exp_rdy;
    int         sum;

    // BI packed req0 in the low bits.
    tbl[0] = '{bi: 8'hE4, en: 4'b1111, sel: 8'hE4, gnt: 4'b1111, nb: 1}; // {0,1,2,3}
    tbl[1] = '{bi: 8'h05, en: 4'b0011, sel: 8'h02, gnt: 4'b0101, nb: 2}; // {1,1,0,0}
    tbl[2] = '{bi: 8'hAA, en: 4'b0100, sel: 8'h00, gnt: 4'b0001, nb: 4}; // {2,2,2,2}
    tbl[3] = '{bi: 8'h73, en: 4'b1011, sel: 8'h0D, gnt: 4'b1011, nb: 2}; // {3,0,3,1}
    tbl[4] = '{bi: 8'h40, en: 4'b0011, sel: 8'h0C, gnt: 4'b1001, nb: 3}; // {0,0,0,1}

    rst_n_i = 1'b0; in_valid_i = 1'b0; bi_bus_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
    exp_cnt = '0;
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_bank_en", bank_en_o, 0);
    chk("rst_sel", sel_bi_bus_o, 0);
    chk("rst_cnt", conflict_cnt_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_n_i = 1'b1; #1;
    chk("rst_in_ready", in_ready_o, 1);

    // Table-driven batches, out_ready held high.
    foreach (tbl[i]) begin
      @(negedge clk_i); in_valid_i = 1'b1; bi_bus_i = tbl[i].bi; out_ready_i = 1'b1; #1;
      chk("tbl_accept_rdy", in_ready_o, 1);
      @(posedge clk_i);
      @(negedge clk_i); in_valid_i = 1'b0; #1;
      chk("tbl_first_en", bank_en_o, tbl[i].en);
      chk("tbl_first_sel", sel_bi_bus_o, tbl[i].sel);
      chk("tbl_first_gnt", req_grant_o, tbl[i].gnt);
      nb = 0; done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
        if (c > 0) begin @(negedge clk_i); #1; end
        if (out_valid_o) begin
          nb++;
          chk("tbl_in_ready_vs_last", in_ready_o, last_o);
          if (last_o) done = 1'b1;
        end
        @(posedge clk_i);
      end
      chk("tbl_last_seen", done, 1);
      chk("tbl_beats", nb, tbl[i].nb);
      exp_cnt = exp_cnt + 16'(tbl[i].nb - 1);
      @(negedge clk_i); #1;
      chk("tbl_cnt", conflict_cnt_o, exp_cnt);
      chk("tbl_idle", busy_o, 0);
    end

    // {1,1,0,0} with two stalled cycles on beat 1.
    @(negedge clk_i); in_valid_i = 1'b1; bi_bus_i = 8'h05; out_ready_i = 1'b0; #1;
    @(posedge clk_i);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk_i); in_valid_i = 1'b0; out_ready_i = (s == 2); #1;
      chk("stall_en", bank_en_o, 4'b0011);
      chk("stall_sel", sel_bi_bus_o, 8'h02);
      chk("stall_gnt", req_grant_o, 4'b0101);
      chk("stall_last", last_o, 0);
      @(posedge clk_i);
    end
    @(negedge clk_i); #1;
    chk("stall_b2_sel", sel_bi_bus_o, 8'h07);
    chk("stall_b2_gnt", req_grant_o, 4'b1010);
    chk("stall_b2_last", last_o, 1);
    @(posedge clk_i);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk_i); #1;
    chk("stall_cnt", conflict_cnt_o, exp_cnt);

    // Four conflict-free batches back to back.
    b2b[0] = 8'hE4; b2b[1] = 8'h1B; b2b[2] = 8'h4E; b2b[3] = 8'hB1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk_i);
      in_valid_i = (k < 4); bi_bus_i = b2b[k % 4]; out_ready_i = 1'b1; #1;
      chk("b2b_in_ready", in_ready_o, 1);
      if (k > 0) begin
        bt = model_beat(b2b[k-1], 0);
        chk("b2b_out_valid", out_valid_o, 1);
        chk("b2b_sel", sel_bi_bus_o, bt.sel);
        chk("b2b_last", last_o, 1);
      end
      @(posedge clk_i);
    end
    @(negedge clk_i); in_valid_i = 1'b0; #1;
    chk("b2b_idle", busy_o, 0);
    chk("b2b_cnt", conflict_cnt_o, exp_cnt);

    // Flush during beat 1 of {2,2,2,2}.
    in_valid_i = 1'b1; bi_bus_i = 8'hAA; #1;
    @(posedge clk_i);
    @(negedge clk_i); in_valid_i = 1'b1; flush_i = 1'b1; #1;
    chk("flush_in_ready", in_ready_o, 0);
    @(posedge clk_i);
    @(negedge clk_i); flush_i = 1'b0; in_valid_i = 1'b0; #1;
    chk("flush_busy", busy_o, 0);
    chk("flush_out_valid", out_valid_o, 0);
    chk("flush_cnt", conflict_cnt_o, exp_cnt);

    // Randomised traffic against the queue model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk_i);
      in_valid_i  = ($urandom_range(3) != 0);
      bi_bus_i    = 8'($urandom);
      out_ready_i = ($urandom_range(3) != 0);
      flush_i     = ($urandom_range(49) == 0);
      #1;
      exp_rdy = !flush_i && (expq.size() == 0 || (expq.size() == 1 && out_ready_i));
      chk("rnd_in_ready", in_ready_o, exp_rdy);
      chk("rnd_out_valid", out_valid_o, expq.size() != 0);
      chk("rnd_cnt", conflict_cnt_o, exp_cnt);
      if (expq.size() != 0) begin
        chk("rnd_bank_en", bank_en_o, expq[0].b.en);
        chk("rnd_sel", sel_bi_bus_o, expq[0].b.sel);
        chk("rnd_gnt", req_grant_o, expq[0].b.gnt);
        chk("rnd_last", last_o, expq.size() == 1);
      end
      if (flush_i) begin
        expq.delete();
      end else begin
        if (expq.size() != 0 && out_ready_i) begin
          if (expq.size() == 1) begin
            sum = int'(exp_cnt) + expq[0].extra;
            exp_cnt = (sum > 65535) ? 16'hFFFF : 16'(sum);
          end
          void'(expq.pop_front());
        end
        if (in_valid_i && exp_rdy) begin
          n = model_nbeats(bi_bus_i);
          for (int k = 0; k < n; k++) begin
            e.b = model_beat(bi_bus_i, k);
            e.extra = n - 1;
            expq.push_back(e);
          end
        end
      end
      @(posedge clk_i);
    end
    // Drain.
    @(negedge clk_i); in_valid_i = 1'b0; flush_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i); flush_i = 1'b0; #1;
    chk("drain_busy", busy_o, 0);

    // Async reset during beat 2 of {2,2,2,2}.
    in_valid_i = 1'b1; bi_bus_i = 8'hAA; #1;
    @(posedge clk_i);
    @(negedge clk_i); in_valid_i = 1'b0; #1;
    @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("rstmid_beat2_valid", out_valid_o, 1);
    chk("rstmid_beat2_gnt", req_grant_o, 4'b0010);
    rst_n_i = 1'b0; #1;
    chk("rstmid_out_valid", out_valid_o, 0);
    chk("rstmid_bank_en", bank_en_o, 0);
    chk("rstmid_gnt", req_grant_o, 0);
    chk("rstmid_sel", sel_bi_bus_o, 0);
    chk("rstmid_last", last_o, 0);
    chk("rstmid_cnt", conflict_cnt_o, 0);
    @(posedge clk_i);
    @(negedge clk_i); rst_n_i = 1'b1; #1;
    chk("rstrel_busy", busy_o, 0);
    chk("rstrel_in_ready", in_ready_o, 1);
    chk("rstrel_cnt", conflict_cnt_o, 0);
    @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("rstrel_no_beat", out_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
